// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for a muxed SAR ADC: walks the enabled channels, settles the mux,
// handshakes one conversion per channel and reports each result with its channel.
module adc_scan_sequencer #(
  parameter int NCH     = 4,
  parameter int DW      = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 16,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [NCH-1:0] chan_en,
  input  logic           continuous,
  output logic           adc_go,
  input  logic           adc_valid,
  input  logic [DW-1:0]  adc_result,
  output logic [CW-1:0]  ch_sel,
  output logic [DW-1:0]  data_out,
  output logic [CW-1:0]  data_ch,
  output logic           data_valid,
  output logic           scan_done,
  output logic           busy,
  output logic           err
);

  localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CNTW = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONV, S_GAP} state_t;

  state_t          state;
  logic [NCH-1:0]  scan_mask;
  logic [CNTW-1:0] cnt;
  logic [NCH-1:0]  higher;

  function automatic logic [CW-1:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) lowest = CW'(i);
  endfunction

  function automatic logic [NCH-1:0] above(input logic [NCH-1:0] m, input logic [CW-1:0] c);
    above = '0;
    for (int i = 0; i < NCH; i++)
      above[i] = m[i] && (i > int'(c));
  endfunction

  assign higher = above(scan_mask, ch_sel);

  // cnt is shared: settle cycles in S_SETTLE, conversion cycles in S_CONV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      scan_mask  <= '0;
      cnt        <= '0;
      adc_go     <= 1'b0;
      ch_sel     <= '0;
      data_out   <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      scan_done  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      scan_done  <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        adc_go <= 1'b0;
        busy   <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && (|chan_en)) begin
              scan_mask <= chan_en;
              ch_sel    <= lowest(chan_en);
              err       <= 1'b0;
              cnt       <= '0;
              busy      <= 1'b1;
              state     <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (cnt == CNTW'(SETTLE - 1)) begin
              cnt    <= '0;
              adc_go <= 1'b1;
              state  <= S_CONV;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_CONV: begin
            // a result arriving on the timeout cycle still counts as a good conversion
            if (adc_valid) begin
              data_out   <= adc_result;
              data_ch    <= ch_sel;
              data_valid <= 1'b1;
              adc_go     <= 1'b0;
              cnt        <= '0;
              state      <= S_GAP;
            end else if (cnt == CNTW'(TIMEOUT - 1)) begin
              err    <= 1'b1;
              adc_go <= 1'b0;
              cnt    <= '0;
              state  <= S_GAP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (|higher) begin
              ch_sel <= lowest(higher);
              state  <= S_SETTLE;
            end else begin
              scan_done <= 1'b1;
              if (continuous) begin
                ch_sel <= lowest(scan_mask);
                state  <= S_SETTLE;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: SAR model, table of scan scenarios checked against
// a timing/ordering reference model, plus hand sequences for continuous, abort and reset.
module tb_adc_scan_sequencer;
  localparam int NCH = 4, DW = 8, SETTLE = 4, TIMEOUT = 16, CW = 2;

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic [NCH-1:0] chan_en = '0;
  logic           adc_go, adc_valid, data_valid, scan_done, busy, err;
  logic [DW-1:0]  adc_result, data_out;
  logic [CW-1:0]  ch_sel, data_ch;

  adc_scan_sequencer #(.NCH(NCH), .DW(DW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chan_en(chan_en),
    .continuous(continuous), .adc_go(adc_go), .adc_valid(adc_valid), .adc_result(adc_result),
    .ch_sel(ch_sel), .data_out(data_out), .data_ch(data_ch), .data_valid(data_valid),
    .scan_done(scan_done), .busy(busy), .err(err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SAR model: result valid sar_dly cycles after go rises, never for channels in hang
  int             sar_cnt = 0;
  int             sar_dly = 11;
  logic [NCH-1:0] hang = '0;
  logic [DW-1:0]  sar_val = '0;
  logic [DW-1:0]  pres_q[$];
  assign adc_valid  = adc_go && (sar_cnt == sar_dly) && !hang[ch_sel];
  assign adc_result = sar_val;
  always @(posedge clk) begin
    if (adc_valid) pres_q.push_back(sar_val);
    if (adc_go) sar_cnt <= sar_cnt + 1;
    else begin
      sar_cnt <= 0;
      sar_val <= DW'($urandom);
    end
  end

  typedef struct { int t; logic [CW-1:0] ch; logic [DW-1:0] d; } dv_t;
  dv_t dv_q[$];
  int  sd_q[$];
  always @(negedge clk) begin
    if (data_valid) dv_q.push_back('{cyc, data_ch, data_out});
    if (scan_done)  sd_q.push_back(cyc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_adc_go"}, adc_go, 0);
    chk({tag, "_ch_sel"}, ch_sel, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_data_ch"}, data_ch, 0);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_scan_done"}, scan_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  typedef struct {
    logic [NCH-1:0] mask;
    logic [NCH-1:0] hang;
    int             dly;
    int             exp_n;
    logic           exp_err;
  } vec_t;
  vec_t tbl[$];

  // Reference: each enabled channel costs SETTLE + conversion + 1 GAP cycle,
  // a conversion is dly+1 cycles or TIMEOUT when no result ever arrives.
  task automatic run_scan(input int idx, input vec_t v);
    int exp_t[$];
    int exp_ch[$];
    int t, c0, fall, dv0, sd0, p0;
    bit h;
    string nm;
    nm = $sformatf("scan%0d", idx);
    t = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (v.mask[ch]) begin
        h = v.hang[ch] || (v.dly >= TIMEOUT);
        t += SETTLE + (h ? TIMEOUT : v.dly + 1);
        if (!h) begin
          exp_t.push_back(t);
          exp_ch.push_back(ch);
        end
        t += 1;
      end
    end
    chan_en = v.mask; hang = v.hang; sar_dly = v.dly; continuous = 1'b0;
    dv0 = dv_q.size(); sd0 = sd_q.size(); p0 = pres_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    repeat (2) @(negedge clk);
    chan_en = NCH'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fall = -1;
    for (int k = 0; k < 400; k++) begin
      if (!busy) begin
        fall = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk({nm, "_busy_fall"}, fall, t);
    chk({nm, "_nvalid"}, dv_q.size() - dv0, v.exp_n);
    chk({nm, "_model_n"}, exp_t.size(), v.exp_n);
    for (int i = 0; i < exp_t.size() && dv0 + i < dv_q.size(); i++) begin
      chk($sformatf("%s_t%0d", nm, i), dv_q[dv0 + i].t - c0, exp_t[i]);
      chk($sformatf("%s_ch%0d", nm, i), dv_q[dv0 + i].ch, exp_ch[i]);
      if (p0 + i < pres_q.size())
        chk($sformatf("%s_d%0d", nm, i), dv_q[dv0 + i].d, pres_q[p0 + i]);
      else
        chk($sformatf("%s_d%0d_present", nm, i), 0, 1);
    end
    chk({nm, "_ndone"}, sd_q.size() - sd0, 1);
    if (sd_q.size() > sd0) chk({nm, "_done_t"}, sd_q[sd0] - c0, t);
    chk({nm, "_err"}, err, v.exp_err);
    hang = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, dv0, sd0, p0, seen, fall;
    vec_t v;

    tbl.push_back('{4'b1010, 4'b0000, 11, 2, 1'b0});
    tbl.push_back('{4'b1111, 4'b0100, 11, 3, 1'b1});
    tbl.push_back('{4'b0110, 4'b0000, 15, 2, 1'b0});
    tbl.push_back('{4'b1001, 4'b0000, 0,  2, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 5,  0, 1'b1});
    for (int i = 0; i < 10; i++) begin
      v.mask = NCH'($urandom_range(1, 15));
      v.hang = ($urandom_range(0, 3) == 0) ? (v.mask & NCH'($urandom)) : '0;
      v.dly  = $urandom_range(0, 15);
      v.exp_n = $countones(v.mask & ~v.hang);
      v.exp_err = |v.hang;
      tbl.push_back(v);
    end

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_scan(i, tbl[i]);

    // start with nothing enabled: stays idle, sticky err untouched
    chan_en = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("zero_mask_busy", busy, 0);
    chk("zero_mask_go", adc_go, 0);
    chk("zero_mask_err", err, 1);

    for (int i = 5; i < tbl.size(); i++) run_scan(i, tbl[i]);

    // continuous single-channel scan, dropped after the third pass completes
    chan_en = 4'b0001; sar_dly = 11; continuous = 1'b1;
    dv0 = dv_q.size(); sd0 = sd_q.size(); p0 = pres_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    seen = 0;
    for (int k = 0; k < 200 && seen < 3; k++) begin
      @(negedge clk);
      if (scan_done) seen++;
    end
    chk("cont_three_passes", seen, 3);
    continuous = 1'b0;
    fall = -1;
    for (int k = 0; k < 100; k++) begin
      if (!busy) begin
        fall = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("cont_busy_fall", fall, 4 * (SETTLE + 13));
    chk("cont_nvalid", dv_q.size() - dv0, 4);
    chk("cont_ndone", sd_q.size() - sd0, 4);
    for (int i = 0; i < 4 && dv0 + i < dv_q.size() && p0 + i < pres_q.size(); i++) begin
      chk($sformatf("cont_t%0d", i), dv_q[dv0 + i].t - c0, SETTLE + 12 + i * (SETTLE + 13));
      chk($sformatf("cont_ch%0d", i), dv_q[dv0 + i].ch, 0);
      chk($sformatf("cont_d%0d", i), dv_q[dv0 + i].d, pres_q[p0 + i]);
    end
    for (int i = 0; i < 4 && sd0 + i < sd_q.size(); i++)
      chk($sformatf("cont_done_t%0d", i), sd_q[sd0 + i] - c0, (i + 1) * (SETTLE + 13));

    // abort during the conversion of channel 1
    chan_en = 4'b0011;
    dv0 = dv_q.size(); sd0 = sd_q.size(); p0 = pres_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (data_valid) seen = 1;
    end
    chk("abort_ch0_valid", seen, 1);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (adc_go) seen = 1;
    end
    chk("abort_ch1_go", seen, 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_go", adc_go, 0);
    chk("abort_busy", busy, 0);
    repeat (30) @(negedge clk);
    chk("abort_nvalid", dv_q.size() - dv0, 1);
    chk("abort_ndone", sd_q.size() - sd0, 0);
    if (p0 < pres_q.size()) chk("abort_data_kept", data_out, pres_q[p0]);
    else chk("abort_data_present", 0, 1);
    chk("abort_ch_kept", data_ch, 0);
    chk("abort_idle", busy, 0);

    // abort beats start in the same cycle
    chan_en = 4'b1111; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    repeat (6) @(negedge clk);
    chk("abort_start_go", adc_go, 0);

    // asynchronous reset in the middle of a conversion
    chan_en = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (adc_go) seen = 1;
    end
    chk("arst_go_before", seen, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_stay_idle", busy, 0);
    chk("arst_no_go", adc_go, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NCH, 4: number of analog mux channels (2..16).
REQ-003 Parameter DW, 8: SAR result width.
REQ-004 Parameter SETTLE, 4: mux settling cycles before each conversion (>=1).
REQ-005 Parameter TIMEOUT, 16: maximum CONV cycles without adc_valid (>= DW+3).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  begin a scan when idle.
REQ-009 abort  in  1  stop immediately.
REQ-010 chan_en  in  NCH  channel enable mask.
REQ-011 continuous  in  1  repeat the scan while high.
REQ-012 adc_go  out  1  to SAR controller go.
REQ-013 adc_valid  in  1  from SAR controller valid.
REQ-014 adc_result  in  DW  from SAR controller result.
REQ-015 ch_sel  out  clog2(NCH)  analog mux select.
REQ-016 data_out  out  DW  last captured result.
REQ-017 data_ch  out  clog2(NCH)  channel of data_out.
REQ-018 data_valid  out  1  one-cycle pulse for a new data_out.
REQ-019 scan_done  out  1  one-cycle pulse at the end of each pass.
REQ-020 busy  out  1  high in any state except IDLE.
REQ-021 err  out  1  sticky conversion-timeout flag.

Function
REQ-022 The FSM SHALL have exactly the states IDLE, SETTLE, CONV and GAP; all outputs SHALL be registered.
REQ-023 IDLE: start=1 with chan_en!=0 SHALL latch chan_en into scan_mask, set ch_sel to the lowest enabled channel, clear err, and enter SETTLE next cycle.
REQ-024 IDLE with start=1 and chan_en=0 SHALL remain in IDLE with no other effect.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 SETTLE SHALL last exactly SETTLE cycles with adc_go=0, then enter CONV.
REQ-027 CONV SHALL hold adc_go=1 and ch_sel stable.
REQ-028 CONV with adc_valid=1 SHALL capture adc_result into data_out and ch_sel into data_ch, pulse data_valid in the following cycle, and enter GAP.
REQ-029 CONV lasting TIMEOUT cycles without adc_valid SHALL set err, leave data_out and data_ch unchanged, pulse no data_valid, and enter GAP.
REQ-030 If adc_valid and the timeout coincide in the same cycle, adc_valid SHALL win.
REQ-031 GAP SHALL last exactly one cycle with adc_go=0, so the SAR controller returns to its wait state.
REQ-032 In GAP, if scan_mask has an enabled channel above ch_sel, the block SHALL select the next higher one and enter SETTLE.
REQ-033 In GAP, if no higher channel is enabled, the block SHALL pulse scan_done and evaluate continuous in that cycle:
- continuous=1: wrap ch_sel to the lowest scan_mask channel and enter SETTLE.
- continuous=0: enter IDLE.
REQ-034 scan_mask SHALL change only in IDLE; changes to chan_en during a scan SHALL have no effect until the next start.
REQ-035 abort=1 in any state SHALL force IDLE on the next edge, drive adc_go=0, and suppress data_valid and scan_done; data_out, data_ch and err SHALL be kept.
REQ-036 abort SHALL take priority over start when both are high in the same cycle.
REQ-037 Latency per channel SHALL be SETTLE + SAR conversion cycles + 1 (GAP).

Reset
REQ-038 While rst_n=0: state=IDLE, adc_go=0, ch_sel=0, data_out=0, data_ch=0, data_valid=0, scan_done=0, busy=0, err=0, scan_mask=0, and all counters 0.
REQ-039 Reset assertion mid-conversion SHALL drop adc_go asynchronously.
REQ-040 After rst_n deasserts, the block SHALL wait for a new start.

Verification
REQ-041 The bench SHALL cover these scenarios (NCH=4, DW=8, SETTLE=4, TIMEOUT=16, SAR model valid 11 cycles after go):
- Single scan: chan_en=4'b1010, start pulse -> data_valid pulses for ch 1 then ch 3 with the model values, scan_done once, busy falls.
- Continuous: chan_en=4'b0001, continuous=1 -> repeated ch 0 results, scan_done every pass; continuous dropped -> IDLE after the current pass.
- Timeout: model never asserts valid on ch 2 -> err=1 after 16 CONV cycles, no data_valid for ch 2, scan continues to ch 3.
- Abort: abort in CONV of ch 1 -> adc_go=0 next cycle, IDLE, no data_valid, data_out keeps the ch 0 value.
- Async reset mid-CONV: rst_n low -> adc_go=0 immediately and every output at its REQ-038 value.
- start with chan_en=0, and start while busy -> no state change.
